fd_queue: RTL
=============

// Module: fd_queue
// PURPOSE
//  Parametrised fetch->decode buffer: a DEPTH-entry FIFO of {pc, inst, state} between IF and ID.
//  Replaces the single-entry F/D register; IF keeps fetching while ID stalls, until the queue fills.
//  Any flush source (branch mispredict detected in D or E) empties the queue in one cycle.
//  When empty, it presents a NOP bubble whose PC is chosen so the bubble is never judged a mispredict.
// PARAMETERS
//  PC_W     13  width of word-addressed PC
//  INST_W   32  instruction width
//  STATE_W  2   branch-predictor state width carried with each instruction
//  DEPTH    2   queue entries; power of two, >= 2
//  FLUSH_N  2   number of independent flush (mispredict) inputs
// PORTS
//  CLK      in   1          clock, all state updates on rising edge
//  NRST     in   1          synchronous reset, active-low
//  f_valid  in   1          IF offers {pcF, instF, stateF} this cycle
//  f_ready  out  1          queue can accept; 1 iff count < DEPTH
//  pcF      in   PC_W       PC of offered instruction
//  instF    in   INST_W     offered instruction
//  stateF   in   STATE_W    predictor state of offered instruction
//  stall    in   1          ID cannot consume head this cycle
//  flush    in   FLUSH_N    per-source flush request; OR-reduced
//  nextpc   in   PC_W       redirect PC accompanying a flush
//  validD   out  1          head entry valid (count != 0)
//  pcD      out  PC_W       head PC, or bubble PC when empty
//  instD    out  INST_W     head instruction, or 0 when empty
//  stateD   out  STATE_W    head state, or 0 when empty
//  count    out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  - Push = f_valid & f_ready. Pop = validD & !stall. Both evaluated on the same edge.
//  - Priority per edge: !NRST > |flush > push/pop. Flush beats stall and discards any same-cycle push.
//  - Reset: count=0, rd/wr pointers=0, bubble_pc=all ones; hence validD=0, pcD=all ones,
//    instD=0, stateD=0, f_ready=1. Storage array contents need not be reset.
//  - Flush: count=0, pointers=0, bubble_pc = nextpc - 1 (mod 2^PC_W; nextpc=0 -> all ones).
//  - Latency: an entry pushed into an empty queue appears on pcD/instD/stateD with validD=1 on the next
//    cycle; no same-cycle fall-through.
//  - Outputs: validD=1 -> pcD/instD/stateD = mem[rd_ptr] (combinational read of registered storage).
//    validD=0 -> pcD=bubble_pc, instD=0, stateD=0.
//  - Pop: rd_ptr increments, wraps DEPTH-1 -> 0; bubble_pc <= popped pc so a subsequent bubble
//    carries the PC of the last consumed instruction.
//  - Push: mem[wr_ptr] <= {pcF,instF,stateF}; wr_ptr increments with wrap.
//  - count: +1 push only, -1 pop only, unchanged on both or neither. Never exceeds DEPTH, never < 0.
//  - Full (count=DEPTH): f_ready=0 even if a pop occurs this cycle (no pop-to-push bypass).
//  - Empty & stall: outputs hold bubble; bubble_pc unchanged.
//  - f_ready is a function of registered count only (no combinational path from stall/flush).
//  - Reset asserted mid-operation discards all entries exactly as at power-up.
// TESTING
//  1 Reset: NRST=0 one edge -> validD=0, pcD=13'h1FFF, instD=0, stateD=0, count=0, f_ready=1.
//  2 Streaming: push pc 0x10,0x11,0x12 on consecutive cycles, stall=0 -> validD=1 from cycle 2,
//    pcD 0x10,0x11,0x12 on consecutive cycles, count stays 1, then bubble with pcD=0x12, instD=0.
//  3 Fill/stall: stall=1, push 3 entries with DEPTH=2 -> count=2, f_ready=0, third not accepted;
//    release stall -> pops in order, f_ready=1 the cycle after count drops to 1.
//  4 Flush: count=2, flush=2'b10, nextpc=0x40, simultaneous push -> next cycle count=0, validD=0,
//    pcD=0x3F, instD=0; pushed entry absent. Repeat with nextpc=0 -> pcD=0x1FFF.
//  5 Flush vs stall: stall=1 and flush=2'b01 same edge -> flush wins, queue empty.
//  6 Wrap: DEPTH=4, 10 push/pop cycles with random stall -> pop order equals push order across pointer wrap.

Source files
------------

// File: rtl/fd_queue.sv
// fd_queue: DEPTH-entry fetch->decode FIFO with one-cycle flush and a mispredict-safe bubble PC
module fd_queue #(
  parameter int PC_W    = 13,
  parameter int INST_W  = 32,
  parameter int STATE_W = 2,
  parameter int DEPTH   = 2,
  parameter int FLUSH_N = 2
) (
  input  logic                     CLK,
  input  logic                     NRST,
  input  logic                     f_valid,
  output logic                     f_ready,
  input  logic [PC_W-1:0]          pcF,
  input  logic [INST_W-1:0]        instF,
  input  logic [STATE_W-1:0]       stateF,
  input  logic                     stall,
  input  logic [FLUSH_N-1:0]       flush,
  input  logic [PC_W-1:0]          nextpc,
  output logic                     validD,
  output logic [PC_W-1:0]          pcD,
  output logic [INST_W-1:0]        instD,
  output logic [STATE_W-1:0]       stateD,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INST_W + STATE_W;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0] bub_q, bub_d;
  logic [EW-1:0]   head;
  logic            fl, push, pop;
  assign fl      = |flush;
  assign f_ready = cnt_q < CW'(DEPTH);
  assign validD  = cnt_q != '0;
  assign push    = f_valid & f_ready;
  assign pop     = validD & ~stall;
  assign head    = mem_q[rd_q];
  assign pcD     = validD ? head[EW-1 -: PC_W] : bub_q;
  assign instD   = validD ? head[STATE_W +: INST_W] : '0;
  assign stateD  = validD ? head[STATE_W-1:0] : '0;
  assign count   = cnt_q;
  // bubble PC tracks the last consumed PC, or redirect-1, so ID never sees it as a mispredict
  always_comb begin
    rd_d  = fl ? '0 : rd_q + AW'(pop);
    wr_d  = fl ? '0 : wr_q + AW'(push);
    cnt_d = fl ? '0 : cnt_q + CW'(push) - CW'(pop);
    bub_d = fl ? nextpc - PC_W'(1) : pop ? head[EW-1 -: PC_W] : bub_q;
  end
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      bub_q <= '1;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      bub_q <= bub_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (NRST && push && !fl) mem_q[wr_q] <= {pcF, instF, stateF};
  end
endmodule
